// File: rtl/frame_deserializer_if.sv
// frame_deserializer_if: word-in / frame-out handshake bundle for the frame deserializer.
interface frame_deserializer_if #(
  parameter int FRAME_SIZE = 4,
  parameter int WORD_SIZE  = 16
);
  localparam int CW = FRAME_SIZE > 1 ? $clog2(FRAME_SIZE) : 1;
  logic                            valid_i;
  logic                            ready_o;
  logic [WORD_SIZE-1:0]            data_r_i;
  logic                            flush_i;
  logic                            valid_o;
  logic                            ready_i;
  logic [FRAME_SIZE*WORD_SIZE-1:0] data_r_o;
  logic [CW-1:0]                   count_o;
  modport master (
    output valid_i, data_r_i, flush_i, ready_i,
    input  ready_o, valid_o, data_r_o, count_o
  );
  modport slave (
    input  valid_i, data_r_i, flush_i, ready_i,
    output ready_o, valid_o, data_r_o, count_o
  );
endinterface

// File: rtl/frame_deserializer.sv
// frame_deserializer: packs FRAME_SIZE serial words into one parallel frame with valid-ready on both sides.
module frame_deserializer #(
  parameter int FRAME_SIZE = 4,
  parameter int WORD_SIZE  = 16
) (
  input logic                clk_i,
  input logic                reset_n_i,
  frame_deserializer_if.slave bus
);
  localparam int CW = FRAME_SIZE > 1 ? $clog2(FRAME_SIZE) : 1;
  localparam int FW = FRAME_SIZE * WORD_SIZE;
  localparam logic [CW-1:0] LAST = CW'(FRAME_SIZE - 1);
  logic [CW-1:0] count;
  logic [FW-1:0] fill;
  logic [FW-1:0] frame;
  logic [FW-1:0] frame_d;
  logic          valid;
  logic          last;
  logic          ready;
  logic          accept;
  logic          take;
  // only the final word must wait for the held frame; earlier words fill behind it
  always_comb begin
    last    = count == LAST;
    ready   = !bus.flush_i && (!last || !valid || bus.ready_i);
    accept  = bus.valid_i && ready;
    take    = valid && bus.ready_i;
    frame_d = fill;
    frame_d[(FRAME_SIZE-1)*WORD_SIZE +: WORD_SIZE] = bus.data_r_i;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count <= '0;
      fill  <= '0;
      frame <= '0;
      valid <= 1'b0;
    end else begin
      if (bus.flush_i) count <= '0;
      else if (accept) begin
        count <= last ? '0 : count + 1'b1;
        if (!last) fill[int'(count)*WORD_SIZE +: WORD_SIZE] <= bus.data_r_i;
      end
      if (accept && last) begin
        frame <= frame_d;
        valid <= 1'b1;
      end else if (take) valid <= 1'b0;
    end
  end
  assign bus.ready_o  = ready;
  assign bus.valid_o  = valid;
  assign bus.data_r_o = frame;
  assign bus.count_o  = count;
endmodule

// File: tb/tb_frame_deserializer.sv
// tb_frame_deserializer: directed checks of reset, packing, backpressure, flush and mid-frame reset.
module tb_frame_deserializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [15:0] w [12];
  int acc;
  int nf;
  always #5 clk = ~clk;
  frame_deserializer_if #(.FRAME_SIZE(4), .WORD_SIZE(16)) bus ();
  frame_deserializer #(.FRAME_SIZE(4), .WORD_SIZE(16)) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic put(input logic [15:0] d);
    bus.valid_i  = 1'b1;
    bus.data_r_i = d;
    step();
  endtask
  initial begin
    bus.valid_i  = 1'b0;
    bus.data_r_i = '0;
    bus.flush_i  = 1'b0;
    bus.ready_i  = 1'b0;
    #3;
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_data", bus.data_r_o, 0);
    chk("rst_count", bus.count_o, 0);
    chk("rst_ready", bus.ready_o, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // frame A, downstream always ready
    bus.ready_i = 1'b1;
    put(16'h0001);
    chk("a_count1", bus.count_o, 1);
    put(16'h0002);
    put(16'hFFFE);
    chk("a_count3", bus.count_o, 3);
    bus.valid_i  = 1'b1;
    bus.data_r_i = 16'h7FFF;
    #1 chk("a_ready_last", bus.ready_o, 1);
    chk("a_not_early", bus.valid_o, 0);
    step();
    bus.valid_i = 1'b0;
    chk("a_valid", bus.valid_o, 1);
    chk("a_data", bus.data_r_o, 64'h7FFF_FFFE_0002_0001);
    chk("a_count0", bus.count_o, 0);
    step();
    chk("a_one_cycle", bus.valid_o, 0);
    chk("a_data_kept", bus.data_r_o, 64'h7FFF_FFFE_0002_0001);
    // frame A held with ready_i low while frame B fills behind it
    bus.ready_i = 1'b0;
    put(16'h0001);
    put(16'h0002);
    put(16'hFFFE);
    put(16'h7FFF);
    bus.valid_i = 1'b0;
    chk("ha_valid", bus.valid_o, 1);
    put(16'h1111);
    chk("b_count1", bus.count_o, 1);
    put(16'h2222);
    chk("b_count2", bus.count_o, 2);
    put(16'h8000);
    chk("b_count3", bus.count_o, 3);
    bus.valid_i  = 1'b1;
    bus.data_r_i = 16'hABCD;
    #1 chk("b_stall", bus.ready_o, 0);
    step();
    chk("b_stall_count", bus.count_o, 3);
    chk("b_hold_a", bus.data_r_o, 64'h7FFF_FFFE_0002_0001);
    chk("b_hold_valid", bus.valid_o, 1);
    bus.ready_i = 1'b1;
    #1 chk("b_ready_comb", bus.ready_o, 1);
    step();
    bus.valid_i = 1'b0;
    chk("b_valid", bus.valid_o, 1);
    chk("b_data", bus.data_r_o, 64'hABCD_8000_2222_1111);
    chk("b_count0", bus.count_o, 0);
    step();
    chk("b_taken", bus.valid_o, 0);
    // three frames with gapped valid_i
    for (int i = 0; i < 12; i++) w[i] = 16'h0100 + 16'(i * 16'h0011);
    acc = 0;
    nf  = 0;
    for (int c = 0; c < 60 && nf < 3; c++) begin
      bus.valid_i  = (acc < 12) && (c % 3 != 1);
      bus.data_r_i = w[acc % 12];
      if (bus.valid_i) acc++;
      step();
      if (bus.valid_o) begin
        chk("gap_frame", bus.data_r_o, {w[4*nf+3], w[4*nf+2], w[4*nf+1], w[4*nf]});
        nf++;
      end
    end
    bus.valid_i = 1'b0;
    chk("gap_nframes", 64'(nf), 3);
    // flush drops a partial frame
    put(16'hAAAA);
    put(16'hBBBB);
    chk("f_count2", bus.count_o, 2);
    bus.flush_i  = 1'b1;
    bus.data_r_i = 16'hCCCC;
    #1 chk("f_ready", bus.ready_o, 0);
    step();
    bus.flush_i = 1'b0;
    chk("f_count0", bus.count_o, 0);
    bus.ready_i = 1'b0;
    put(16'h0011);
    put(16'h0022);
    put(16'h0033);
    put(16'h0044);
    bus.valid_i = 1'b0;
    chk("f_clean", bus.data_r_o, 64'h0044_0033_0022_0011);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    chk("f_pend_valid", bus.valid_o, 1);
    chk("f_pend_data", bus.data_r_o, 64'h0044_0033_0022_0011);
    // reset mid-frame with a pending output frame
    put(16'h5555);
    put(16'h6666);
    bus.valid_i = 1'b0;
    chk("r_count2", bus.count_o, 2);
    #2 rst_n = 1'b0;
    #1 chk("r_valid", bus.valid_o, 0);
    chk("r_count", bus.count_o, 0);
    chk("r_data", bus.data_r_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.ready_i = 1'b1;
    put(16'h9001);
    put(16'h9002);
    put(16'h9003);
    put(16'h9004);
    bus.valid_i = 1'b0;
    chk("r_fresh_valid", bus.valid_o, 1);
    chk("r_fresh_data", bus.data_r_o, 64'h9004_9003_9002_9001);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
